// File: rtl/seq_subtractor.sv
// ---------------------------------------------------------------------------
// seq_subtractor
//   Multi-cycle subtractor: diff = a - b computed as a + ~b + 1, CHUNK bits
//   per RUN cycle, with the ripple carry held in a flop between cycles.
//   Valid/ready handshake on both the operand and the result side.
//
//   Optional feature macro: SUB_FLAGS_EN
//     defined   -> flags_out = {N,Z,C,V} (ARM semantics), registered on RUN->DONE
//     undefined -> flags_out tied to 4'b0000, no flag logic
//
// Parameters
//   WIDTH  operand/result width
//   CHUNK  bits processed per RUN cycle (WIDTH % CHUNK == 0)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operands presented          in_ready   high only in IDLE
//   a_in       minuend                     b_in       subtrahend
//   out_valid  result valid until accepted out_ready  consumer accepts result
//   diff_out   a_in - b_in mod 2^WIDTH     flags_out  {N,Z,C,V}
// ---------------------------------------------------------------------------
module seq_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic [3:0]       flags_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the index at least one bit wide so CHUNK == WIDTH still elaborates.
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;      // subtrahend stored pre-inverted
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CHUNK:0]     chunk_sum;
`ifdef SUB_FLAGS_EN
    logic [3:0]         flags_q, flags_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        nb_d      = nb_q;
        diff_d    = diff_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
`ifdef SUB_FLAGS_EN
        flags_d   = flags_q;
`endif
        chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                  + {1'b0, nb_q[idx_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                // in_ready is high whenever we are in IDLE
                if (in_valid) begin
                    a_d     = a_in;
                    nb_d    = ~b_in;
                    carry_d = 1'b1;       // the +1 of two's complement negation
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    state_d = DONE;
`ifdef SUB_FLAGS_EN
                    // diff_d already holds the final chunk here
                    flags_d[3] = diff_d[WIDTH-1];
                    flags_d[2] = (diff_d == '0);
                    flags_d[1] = chunk_sum[CHUNK];     // 1 = no borrow
                    flags_d[0] = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) &&
                                 (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b1;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_FLAGS_EN
            flags_q     <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            diff_q      <= diff_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff_out  = diff_q;
`ifdef SUB_FLAGS_EN
    assign flags_out = flags_q;
`else
    assign flags_out = 4'b0000;
`endif

endmodule
